// File: rtl/reload_timer_pkg.sv
// Shared definitions for the reload down-timer: FSM state encoding and default width.
package reload_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Zero detect kept as a helper so every consumer agrees on what "expired" means.
    function automatic logic is_zero(input logic [DEFAULT_WIDTH-1:0] value);
        return (value == {DEFAULT_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/reload_down_timer.sv
// Programmable down-counting timer with reload register, one-shot/periodic expiry and
// a registered one-cycle expiry pulse. All outputs come straight from flops.
module reload_down_timer
    import reload_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] reload_o,
    output logic             busy_o,
    output logic             expire_o
);

    timer_state_t     state_r;
    timer_state_t     state_next_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_next_s;
    logic             expire_r;
    logic             expire_next_s;
    logic             busy_r;
    logic             count_zero_s;

    assign count_zero_s = (count_r == {WIDTH{1'b0}});

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: stop beats load, load keeps RUN alive, zero in one-shot returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_next_s = IDLE;
                end else if (load_i) begin
                    state_next_s = RUN;
                end else if (count_zero_s && !periodic_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath next values: counter, reload register and expiry pulse.
    always_comb begin
        count_next_s  = count_r;
        reload_next_s = reload_r;
        expire_next_s = 1'b0;
        if (stop_i) begin
            count_next_s  = count_r;
            reload_next_s = reload_r;
        end else if (load_i) begin
            count_next_s  = load_val_i;
            reload_next_s = load_val_i;
        end else if (state_r != RUN) begin
            if (start_i) begin
                count_next_s = reload_r;
            end else begin
                count_next_s = count_r;
            end
        end else if (!count_zero_s) begin
            count_next_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            expire_next_s = 1'b1;
            if (periodic_i) begin
                count_next_s = reload_r;
            end else begin
                count_next_s = count_r;
            end
        end
    end

    // Output and datapath registers; busy is registered from the next state so it tracks state_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= {WIDTH{1'b0}};
            reload_r <= {WIDTH{1'b0}};
            expire_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            count_r  <= count_next_s;
            reload_r <= reload_next_s;
            expire_r <= expire_next_s;
            busy_r   <= (state_next_s == RUN);
        end
    end

    assign count_o  = count_r;
    assign reload_o = reload_r;
    assign busy_o   = busy_r;
    assign expire_o = expire_r;

endmodule

// File: doc/reload_down_timer.md
# reload_down_timer

Programmable down-counting timer with a reload register. It complements the loadable up-counter: it counts down from a loaded value instead of up to all-ones. On reaching zero it emits a one-cycle expiry pulse, then either reloads (periodic mode) or stops (one-shot mode). It serves as a tick/timeout generator beside the counter blocks, with software- or FSM-driven load/start/stop.

## Interface
- WIDTH, 4, counter and reload register width.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clock clk.
- load_i  input  1  write load_val_i into reload register and counter.
- load_val_i  input  WIDTH  value captured on load_i.
- start_i  input  1  IDLE→RUN request; ignored in RUN.
- stop_i  input  1  RUN→IDLE abort; no expiry generated.
- periodic_i  input  1  1 = reload and keep running on expiry; 0 = one-shot.
- count_o  output  WIDTH  current counter value (count_q).
- reload_o  output  WIDTH  current reload register value.
- busy_o  output  1  high while in RUN.
- expire_o  output  1  registered one-cycle pulse, asserted the cycle after an expiry edge.

## Operation
- Reset: state IDLE, count_q=0, reload_q=0, busy_o=0, expire_o=0.
- States: IDLE, RUN. busy_o = (state==RUN).
- Per-edge priority: reset > stop_i > load_i > start_i / decrement / expiry.
- load_i, any state: reload_q ← load_val_i and count_q ← load_val_i. State unchanged, except that start_i in the same IDLE cycle still enters RUN with count_q = load_val_i. No expiry on that edge, even if count_q==0 in RUN.
- IDLE + start_i (no stop_i): → RUN. count_q ← reload_q, or load_val_i if load_i is also high.
- IDLE otherwise: count_q holds.
- RUN, count_q≠0, no load/stop: count_q ← count_q−1.
- RUN, count_q==0, no load/stop: expiry edge.
  - expire_o ← 1.
  - periodic_i=1: count_q ← reload_q, stay RUN.
  - periodic_i=0: → IDLE, count_q stays 0.
  - periodic_i is sampled only on expiry edges.
- RUN + stop_i: → IDLE, count_q holds current value, expire_o ← 0. stop_i also overrides a simultaneous load_i; reload_q is then not written.
- IDLE + start_i + stop_i: stay IDLE.
- start_i in RUN: ignored (no restart).
- Arithmetic is unsigned modulo 2^WIDTH. Decrement never wraps because zero is always an expiry or a hold.

## Timing
- Loaded value N, start_i sampled at edge t0: count_q = N after t0, N−k after t0+k, 0 after t0+N.
- Expiry edge is t0+N+1; expire_o is high for the cycle after t0+N+1.
- Period in periodic mode: N+1 cycles between expire_o pulses.
- N=0 periodic: expire_o stays high continuously from the cycle after t0+1 (one expiry per cycle).
- expire_o is never high for two cycles for a one-shot run. busy_o drops on the same edge that raises expire_o.
- Reset asserted mid-run: all outputs go to reset values asynchronously; no expiry pulse.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package reload_timer_pkg holds:
  - typedef enum logic {IDLE, RUN} timer_state_t;
  - localparam default WIDTH.
- Single module; no sub-module is natural. Reload register, counter, FSM, and expiry flop live in one always_ff plus next-state logic.

## Test plan
- Reset then idle: after reset, count_o=0, reload_o=0, busy_o=0, expire_o=0; start_i without a load → RUN with count 0, expire_o pulse 2 cycles after start edge, periodic_i=0 → IDLE.
- One-shot: load 5, start, periodic_i=0 → count_o 5,4,3,2,1,0; expire_o single pulse 7 cycles after start edge; busy_o falls with it; count_o stays 0.
- Periodic: load 3, start, periodic_i=1 for 20 cycles → expire_o every 4 cycles; count_o sequence 3,2,1,0,3,…; deassert periodic_i → next expiry returns to IDLE.
- Load mid-run: load 9, start, at count 4 apply load_i with value 2 → count_o 2,1,0, reload_o=2, subsequent periods 3 cycles; load_i at count 0 suppresses that expiry.
- Stop/priority: running at count 6, assert stop_i with load_i (value 1) → IDLE, count_o=6, reload_o unchanged, no expire_o; start_i+stop_i in IDLE → stays IDLE.
- Async reset at count 2 in RUN → outputs zero immediately (before next edge); no expire_o afterwards.
